// File: rtl/par_ni_gen.sv
// par_ni_gen: NoC node traffic source (LFSR destinations, TX queue) and sink with saturating stats.
// Optional PAR_NI_SEQ_CHECK_EN adds per-source sequence checking and the seq_err_count output.
module par_ni_gen #(
   parameter int NUM_NODES = 2,
   parameter int ADDR_SZ = 4,
   parameter int PL_SZ = 16,
   parameter int HDR_SZ = 2,
   parameter logic [HDR_SZ-1:0] HDR_VAL = 2'b01,
   parameter int FIFO_DEPTH = 4,
   parameter int INJ_PERIOD = 8,
   parameter int CNT_W = 32,
   localparam int FW = HDR_SZ + PL_SZ + ADDR_SZ
) (
   input  logic clk,
   input  logic reset,
   input  logic [ADDR_SZ-1:0] id,
   input  logic send_en,
   output logic [FW-1:0] item_out,
   output logic req,
   input  logic channel_busy,
   input  logic [FW-1:0] item_in,
   input  logic valid,
   output logic busy,
   output logic [CNT_W-1:0] tx_count,
   output logic [CNT_W-1:0] rx_count,
   output logic [CNT_W-1:0] drop_count,
   output logic [CNT_W-1:0] err_count
`ifdef PAR_NI_SEQ_CHECK_EN
   ,
   output logic [CNT_W-1:0] seq_err_count
`endif
);
   localparam int SW = PL_SZ - ADDR_SZ;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = INJ_PERIOD > 1 ? $clog2(INJ_PERIOD) : 1;
   localparam logic [ADDR_SZ:0] NN = (ADDR_SZ+1)'(NUM_NODES);
   localparam logic [TW-1:0] TLAST = TW'(INJ_PERIOD - 1);
   localparam logic [AW:0] FD = (AW+1)'(FIFO_DEPTH);

   function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
      return &c ? c : c + CNT_W'(1);
   endfunction

   logic [TW-1:0] timer;
   logic [15:0] lfsr, m;
   logic [SW-1:0] seq;
   logic [FW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic [ADDR_SZ-1:0] d0, dest;
   logic [ADDR_SZ:0] d1;
   logic gen, empty, full, pop, push, drop, acc;

   assign gen = send_en && timer == TLAST;
   assign empty = cnt == '0;
   assign full = cnt == FD;
   assign pop = !empty && !channel_busy;
   // a full queue still accepts when the head leaves in the same cycle
   assign push = gen && (!full || pop);
   assign drop = gen && !push;
   assign req = !empty;
   assign item_out = empty ? '0 : mem[rp];
   assign acc = valid && !busy;
   assign m = lfsr % 16'(NUM_NODES);
   assign d0 = m[ADDR_SZ-1:0];
   assign d1 = {1'b0, d0} + (ADDR_SZ+1)'(1);
   assign dest = d0 != id ? d0 : d1 == NN ? '0 : d1[ADDR_SZ-1:0];

   always_ff @(posedge clk)
      if (push) mem[wp] <= {HDR_VAL, id, seq, dest};

   always_ff @(posedge clk) begin
      if (reset) begin
         timer <= '0;
         lfsr <= 16'hACE1 ^ 16'(id);
         seq <= '0;
         wp <= '0;
         rp <= '0;
         cnt <= '0;
         busy <= 1'b1;
         tx_count <= '0;
         rx_count <= '0;
         drop_count <= '0;
         err_count <= '0;
      end else begin
         busy <= 1'b0;
         timer <= !send_en || timer == TLAST ? '0 : timer + TW'(1);
         if (gen) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         if (push) begin
            wp <= wp + AW'(1);
            seq <= seq + SW'(1);
         end
         if (pop) rp <= rp + AW'(1);
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
         if (pop) tx_count <= sat(tx_count);
         if (drop) drop_count <= sat(drop_count);
         if (acc) rx_count <= sat(rx_count);
         if (acc && item_in[ADDR_SZ-1:0] != id) err_count <= sat(err_count);
      end
   end

`ifdef PAR_NI_SEQ_CHECK_EN
   logic [SW-1:0] exp_seq [NUM_NODES];
   logic [SW-1:0] exp_cur, rseq;
   logic [ADDR_SZ-1:0] src;
   logic hit;

   assign src = item_in[PL_SZ+ADDR_SZ-1 -: ADDR_SZ];
   assign rseq = item_in[ADDR_SZ +: SW];

   // hit=0 means the source id is outside the mesh
   always_comb begin
      hit = 1'b0;
      exp_cur = '0;
      for (int i = 0; i < NUM_NODES; i++)
         if (src == ADDR_SZ'(i)) begin
            hit = 1'b1;
            exp_cur = exp_seq[i];
         end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_NODES; i++) exp_seq[i] <= '0;
         seq_err_count <= '0;
      end else if (acc) begin
         if (!hit || rseq != exp_cur) seq_err_count <= sat(seq_err_count);
         for (int i = 0; i < NUM_NODES; i++)
            if (src == ADDR_SZ'(i)) exp_seq[i] <= rseq + SW'(1);
      end
   end
`endif
endmodule

// File: tb/tb_par_ni_gen.sv
// tb_par_ni_gen: directed checks of par_ni_gen on a 2-node/period-4 instance and a 5-node/period-1/3-bit-counter instance.
module tb_par_ni_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic rst_a, en_a, cb_a, valid_a, req_a, busy_a;
   logic [21:0] in_a, out_a;
   logic [31:0] tx_a, rx_a, drop_a, err_a;
   logic rst_b, en_b, cb_b, req_b, busy_b;
   logic [21:0] in_b, out_b;
   logic [2:0] tx_b, rx_b, drop_b, err_b;
`ifdef PAR_NI_SEQ_CHECK_EN
   logic [31:0] serr_a;
   logic [2:0] serr_b;
`endif

   par_ni_gen #(.NUM_NODES(2), .INJ_PERIOD(4)) u_a (
      .clk(clk), .reset(rst_a), .id(4'd0), .send_en(en_a), .item_out(out_a), .req(req_a),
      .channel_busy(cb_a), .item_in(in_a), .valid(valid_a), .busy(busy_a),
      .tx_count(tx_a), .rx_count(rx_a), .drop_count(drop_a), .err_count(err_a)
`ifdef PAR_NI_SEQ_CHECK_EN
      , .seq_err_count(serr_a)
`endif
   );

   par_ni_gen #(.NUM_NODES(5), .INJ_PERIOD(1), .CNT_W(3)) u_b (
      .clk(clk), .reset(rst_b), .id(4'd2), .send_en(en_b), .item_out(out_b), .req(req_b),
      .channel_busy(cb_b), .item_in(in_b), .valid(1'b0), .busy(busy_b),
      .tx_count(tx_b), .rx_count(rx_b), .drop_count(drop_b), .err_count(err_b)
`ifdef PAR_NI_SEQ_CHECK_EN
      , .seq_err_count(serr_b)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [21:0] fl(input logic [3:0] s, input int sq, input logic [3:0] d);
      return {2'b01, s, 12'(sq), d};
   endfunction

   function automatic logic [3:0] mdest(input logic [15:0] l);
      logic [15:0] r;
      r = l % 16'd5;
      return r[3:0] == 4'd2 ? 4'd3 : r[3:0];
   endfunction

   function automatic logic [15:0] mnext(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   task automatic test_reset;
      rst_a = 1; rst_b = 1; en_a = 0; en_b = 0; cb_a = 0; cb_b = 0; valid_a = 0; in_a = '0; in_b = '0;
      tick; tick;
      checks++; if (busy_a !== 1'b1 || busy_b !== 1'b1) begin failures++; $display("FAIL reset_busy got a=%b b=%b want 1", busy_a, busy_b); end
      checks++; if (req_a !== 1'b0 || out_a !== '0) begin failures++; $display("FAIL reset_req got req=%b out=%h want 0", req_a, out_a); end
      checks++; if ({tx_a, rx_a, drop_a, err_a} !== '0) begin failures++; $display("FAIL reset_cnt got %0d %0d %0d %0d want 0", tx_a, rx_a, drop_a, err_a); end
      rst_a = 0; rst_b = 0;
      tick;
      checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin failures++; $display("FAIL reset_busy_rel got a=%b b=%b want 0", busy_a, busy_b); end
   endtask

   task automatic test_stream;
      int s = 0;
      en_a = 1; cb_a = 0;
      for (int i = 1; i <= 40; i++) begin
         tick;
         checks++; if (req_a !== 1'(i % 4 == 0)) begin failures++; $display("FAIL stream_req cyc=%0d got %b want %b", i, req_a, i % 4 == 0); end
         if (i % 4 == 0) begin
            checks++; if (out_a !== fl(4'd0, s, 4'd1)) begin failures++; $display("FAIL stream_flit cyc=%0d got %h want %h", i, out_a, fl(4'd0, s, 4'd1)); end
            s++;
         end
      end
      en_a = 0;
      tick; tick;
      checks++; if (tx_a !== 32'd10 || drop_a !== 32'd0) begin failures++; $display("FAIL stream_cnt got tx=%0d drop=%0d want 10 0", tx_a, drop_a); end
   endtask

   task automatic test_drop;
      logic [21:0] h = '0;
      cb_a = 1; en_a = 1;
      for (int i = 1; i <= 40; i++) begin
         tick;
         if (i == 4) h = out_a;
         if (i > 4) begin
            checks++; if (out_a !== h) begin failures++; $display("FAIL drop_stable cyc=%0d got %h want %h", i, out_a, h); end
         end
      end
      checks++; if (h !== fl(4'd0, 10, 4'd1)) begin failures++; $display("FAIL drop_head got %h want %h", h, fl(4'd0, 10, 4'd1)); end
      checks++; if (drop_a !== 32'd6) begin failures++; $display("FAIL drop_count got %0d want 6", drop_a); end
      en_a = 0; cb_a = 0;
      for (int j = 0; j < 4; j++) begin
         checks++; if (req_a !== 1'b1 || out_a !== fl(4'd0, 10 + j, 4'd1)) begin failures++; $display("FAIL drop_drain j=%0d got req=%b %h want %h", j, req_a, out_a, fl(4'd0, 10 + j, 4'd1)); end
         tick;
      end
      checks++; if (req_a !== 1'b0 || tx_a !== 32'd14) begin failures++; $display("FAIL drop_after got req=%b tx=%0d want 0 14", req_a, tx_a); end
   endtask

   task automatic test_full_pushpop;
      cb_a = 1; en_a = 1;
      repeat (19) tick;
      checks++; if (req_a !== 1'b1 || out_a !== fl(4'd0, 14, 4'd1) || drop_a !== 32'd6) begin failures++; $display("FAIL full_pre got req=%b %h drop=%0d want 1 %h 6", req_a, out_a, drop_a, fl(4'd0, 14, 4'd1)); end
      cb_a = 0;
      tick;
      cb_a = 1; en_a = 0;
      checks++; if (drop_a !== 32'd6 || tx_a !== 32'd15) begin failures++; $display("FAIL full_same got drop=%0d tx=%0d want 6 15", drop_a, tx_a); end
      cb_a = 0;
      for (int j = 0; j < 4; j++) begin
         checks++; if (req_a !== 1'b1 || out_a !== fl(4'd0, 15 + j, 4'd1)) begin failures++; $display("FAIL full_drain j=%0d got req=%b %h want %h", j, req_a, out_a, fl(4'd0, 15 + j, 4'd1)); end
         tick;
      end
      checks++; if (req_a !== 1'b0 || tx_a !== 32'd19) begin failures++; $display("FAIL full_after got req=%b tx=%0d want 0 19", req_a, tx_a); end
   endtask

   task automatic test_sink;
      valid_a = 1;
      for (int i = 0; i < 3; i++) begin in_a = fl(4'd0, i, 4'd1); tick; end
      checks++; if (rx_a !== 32'd3 || err_a !== 32'd3) begin failures++; $display("FAIL sink_bad got rx=%0d err=%0d want 3 3", rx_a, err_a); end
      for (int i = 3; i < 5; i++) begin in_a = fl(4'd0, i, 4'd0); tick; end
      valid_a = 0;
      checks++; if (rx_a !== 32'd5 || err_a !== 32'd3) begin failures++; $display("FAIL sink_good got rx=%0d err=%0d want 5 3", rx_a, err_a); end
   endtask

`ifdef PAR_NI_SEQ_CHECK_EN
   task automatic test_seq_check;
      valid_a = 1;
      in_a = fl(4'd1, 0, 4'd0); tick;
      in_a = fl(4'd1, 1, 4'd0); tick;
      in_a = fl(4'd1, 3, 4'd0); tick;
      checks++; if (serr_a !== 32'd1) begin failures++; $display("FAIL seq_gap got %0d want 1", serr_a); end
      in_a = fl(4'd1, 4, 4'd0); tick;
      checks++; if (serr_a !== 32'd1) begin failures++; $display("FAIL seq_resync got %0d want 1", serr_a); end
      in_a = fl(4'd5, 0, 4'd0); tick;
      valid_a = 0;
      checks++; if (serr_a !== 32'd2 || rx_a !== 32'd10) begin failures++; $display("FAIL seq_badsrc got serr=%0d rx=%0d want 2 10", serr_a, rx_a); end
   endtask
`endif

   task automatic test_reset_mid;
      cb_a = 1; en_a = 1;
      repeat (12) tick;
      checks++; if (req_a !== 1'b1) begin failures++; $display("FAIL mid_pre got req=%b want 1", req_a); end
      rst_a = 1; en_a = 0; cb_a = 0;
      tick;
      checks++; if (req_a !== 1'b0 || out_a !== '0 || busy_a !== 1'b1) begin failures++; $display("FAIL mid_rst got req=%b out=%h busy=%b want 0 0 1", req_a, out_a, busy_a); end
      checks++; if ({tx_a, rx_a, drop_a, err_a} !== '0) begin failures++; $display("FAIL mid_cnt got %0d %0d %0d %0d want 0", tx_a, rx_a, drop_a, err_a); end
`ifdef PAR_NI_SEQ_CHECK_EN
      checks++; if (serr_a !== '0) begin failures++; $display("FAIL mid_serr got %0d want 0", serr_a); end
`endif
      rst_a = 0;
      tick;
      checks++; if (busy_a !== 1'b0 || req_a !== 1'b0) begin failures++; $display("FAIL mid_rel got busy=%b req=%b want 0 0", busy_a, req_a); end
   endtask

   task automatic test_dest_seq;
      logic [15:0] ml = 16'hACE3;
      en_b = 1; cb_b = 0;
      for (int k = 0; k < 12; k++) begin
         tick;
         checks++; if (req_b !== 1'b1 || out_b !== fl(4'd2, k, mdest(ml))) begin failures++; $display("FAIL dest k=%0d got req=%b %h want %h", k, req_b, out_b, fl(4'd2, k, mdest(ml))); end
         ml = mnext(ml);
      end
      en_b = 0;
      tick;
      checks++; if (req_b !== 1'b0 || tx_b !== 3'd7) begin failures++; $display("FAIL dest_sat got req=%b tx=%0d want 0 7", req_b, tx_b); end
   endtask

   task automatic test_back_to_back;
      logic [21:0] h;
      cb_b = 1; en_b = 1;
      tick;
      h = out_b;
      repeat (9) begin
         tick;
         checks++; if (out_b !== h) begin failures++; $display("FAIL b2b_stable got %h want %h", out_b, h); end
      end
      checks++; if (drop_b !== 3'd6 || h[15:4] !== 12'd12) begin failures++; $display("FAIL b2b_drop got drop=%0d seq=%0d want 6 12", drop_b, h[15:4]); end
      en_b = 0; cb_b = 0;
      for (int j = 0; j < 4; j++) begin
         checks++; if (req_b !== 1'b1 || out_b[15:4] !== 12'(12 + j)) begin failures++; $display("FAIL b2b_drain j=%0d got req=%b seq=%0d want %0d", j, req_b, out_b[15:4], 12 + j); end
         tick;
      end
      checks++; if (req_b !== 1'b0) begin failures++; $display("FAIL b2b_empty got req=%b want 0", req_b); end
      cb_b = 1; en_b = 1;
      repeat (6) tick;
      checks++; if (drop_b !== 3'd7) begin failures++; $display("FAIL b2b_dropsat got %0d want 7", drop_b); end
      en_b = 0; cb_b = 0;
      repeat (5) tick;
   endtask

   task automatic test_replay;
      rst_b = 1;
      tick;
      checks++; if (req_b !== 1'b0 || tx_b !== 3'd0 || drop_b !== 3'd0 || busy_b !== 1'b1) begin failures++; $display("FAIL replay_rst got req=%b tx=%0d drop=%0d busy=%b want 0 0 0 1", req_b, tx_b, drop_b, busy_b); end
      rst_b = 0;
      tick;
      test_dest_seq;
   endtask

   initial begin
      test_reset;
      test_stream;
      test_drop;
      test_full_pushpop;
      test_sink;
`ifdef PAR_NI_SEQ_CHECK_EN
      test_seq_check;
`endif
      test_reset_mid;
      test_dest_seq;
      test_back_to_back;
      test_replay;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/par_ni_gen.md
Name: par_ni_gen

Overview:
- Parametrised successor of the par_clib network interface: one synchronous traffic source plus sink per node, attaching to a router's local port (rx_l_*/tx_l_*).
- Generates flits at a programmable injection period to pseudo-random destinations (never self) through a configurable-depth TX queue.
- Consumes delivered flits, checks their destination and keeps saturating statistics counters for NoC benchmarking on N-node meshes.

Parameters:
- NUM_NODES, 2, node count; destinations are 0..NUM_NODES-1; must be >= 2.
- ADDR_SZ, 4, address field width; 2**ADDR_SZ >= NUM_NODES.
- PL_SZ, 16, payload width; must be > ADDR_SZ.
- HDR_SZ, 2, header width.
- HDR_VAL, 2'b01, header value stamped on generated flits.
- FIFO_DEPTH, 4, TX queue entries; power of 2, >= 2.
- INJ_PERIOD, 8, cycles between generated flits while send_en=1; >= 1.
- CNT_W, 32, statistics counter width.
- FW = HDR_SZ+PL_SZ+ADDR_SZ (localparam).

Ports:
- clk  in  1  node clock
- reset  in  1  synchronous, active-high
- id  in  ADDR_SZ  node address; static after reset
- send_en  in  1  enables injection
- item_out  out  FW  flit to router local rx
- req  out  1  item_out valid
- channel_busy  in  1  router local rx busy
- item_in  in  FW  flit from router local tx
- valid  in  1  item_in valid
- busy  out  1  sink not ready
- tx_count  out  CNT_W  flits sent
- rx_count  out  CNT_W  flits received
- drop_count  out  CNT_W  generated flits dropped because the TX queue was full
- err_count  out  CNT_W  received flits with addr != id

Behaviour:
- Flit layout: [FW-1:PL_SZ+ADDR_SZ] = header; [PL_SZ+ADDR_SZ-1:ADDR_SZ] = payload; [ADDR_SZ-1:0] = destination. Payload = {src id (ADDR_SZ bits), seq (PL_SZ-ADDR_SZ bits)}.
- Reset (synchronous): all counters = 0; FIFO empty; req = 0; item_out = 0; timer = 0; seq = 0; LFSR = 16'hACE1 ^ zero-extended id; busy = 1 while reset is high, 0 from the first cycle after.
- Timer: while send_en=1, counts 0..INJ_PERIOD-1 and wraps. A generate event occurs in the cycle the timer equals INJ_PERIOD-1. With INJ_PERIOD=1, a flit is generated every cycle. send_en=0 clears the timer to 0, so no partial period is carried over.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances on every generate event, including drops.
  - dest = LFSR % NUM_NODES; if dest == id, dest = (dest+1) % NUM_NODES.
- seq: increments, wrapping modulo 2**(PL_SZ-ADDR_SZ), only on a successful push (drops do not consume a seq).
- TX FIFO: push on a generate event if not full, or if full and a pop occurs in the same cycle (simultaneous push and pop at full is accepted). Otherwise drop_count += 1.
  - req = !empty; item_out = head entry, or 0 when empty.
  - Handshake: transfer happens in a cycle with req=1 and channel_busy=0. On transfer, pop and tx_count += 1. item_out must be held stable while req=1 and channel_busy=1.
  - Latency: a flit generated in cycle t appears at item_out at t+1 if the queue was empty.
- Sink: accepts item_in in any cycle with valid=1 and busy=0, then rx_count += 1. If item_in[ADDR_SZ-1:0] != id, err_count += 1 as well.
- All counters saturate at 2**CNT_W-1 and never wrap.
- Reset mid-operation: queued flits are discarded and not counted; req drops to 0 in the cycle after reset is sampled.

Optional Feature:
- Macro: PAR_NI_SEQ_CHECK_EN.
- Defined:
  - Adds a per-source expected-seq array (NUM_NODES entries, reset 0) and output seq_err_count (CNT_W, saturating).
  - On each accepted flit from source s: if seq != expected[s], seq_err_count += 1. In all cases expected[s] = seq+1 (wrapping).
  - Source ids >= NUM_NODES increment seq_err_count and do not update the array.
- Undefined: no array and no seq_err_count port; all other behaviour identical.

Test Plan:
- NUM_NODES=2, id=0, INJ_PERIOD=4, channel_busy=0, send_en=1 for 40 cycles -> 10 flits sent, all with dest=1 and seq 0..9; tx_count=10; drop_count=0.
- INJ_PERIOD=1, FIFO_DEPTH=4, channel_busy=1 for 10 cycles -> 4 flits queued, drop_count=6, item_out stable. Then channel_busy=0 -> 4 transfers on consecutive cycles.
- Full queue with generate and transfer in the same cycle -> push accepted; drop_count unchanged; occupancy stays 4.
- Inject item_in with addr=1 to id=0, valid=1 for 3 cycles -> rx_count=3, err_count=3. Then addr=0 twice -> rx_count=5, err_count=3.
- Assert reset for 1 cycle with 3 flits queued -> next cycle: req=0, all counters 0, busy=1 during reset and 0 afterwards; LFSR replays the identical dest sequence.
- With PAR_NI_SEQ_CHECK_EN: receive seq 0,1,3 from source 1 -> seq_err_count=1. A following seq 4 -> no further increment.
